// File: rtl/comp_seq.sv
// comp_seq: clock sequencer for a comparator bank with output sync, phase timeouts and majority voting
module comp_seq #(
    parameter int NCH   = 4,
    parameter int NVOTE = 3,
    parameter int SYNC  = 2,
    parameter int TMO   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    output logic [NCH-1:0] comp_clk,
    input  logic [NCH-1:0] comp_p,
    input  logic [NCH-1:0] comp_n,
    output logic           busy,
    output logic           done,
    output logic [NCH-1:0] result,
    output logic [NCH-1:0] err
);
    localparam int CW = $clog2(TMO);
    localparam int VW = $clog2(NVOTE + 1);

    if (NVOTE < 1 || NVOTE % 2 == 0) begin : g_bad_nvote
        $error("comp_seq: NVOTE must be odd and >= 1");
    end
    if (SYNC < 2) begin : g_bad_sync
        $error("comp_seq: SYNC must be >= 2");
    end
    if (TMO < SYNC + 2) begin : g_bad_tmo
        $error("comp_seq: TMO must be >= SYNC+2");
    end

    typedef enum logic [1:0] {IDLE, EVAL, PRE, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [VW-1:0]  vidx_q, vidx_d;
    logic [VW-1:0]  v_q, v_d;
    logic [VW-1:0]  ones_q [NCH];
    logic [VW-1:0]  ones_d [NCH];
    logic [NCH-1:0] err_acc_q, err_acc_d;
    logic [NCH-1:0] syn_p_q [SYNC];
    logic [NCH-1:0] syn_p_d [SYNC];
    logic [NCH-1:0] syn_n_q [SYNC];
    logic [NCH-1:0] syn_n_d [SYNC];
    logic [NCH-1:0] comp_clk_q, comp_clk_d;
    logic [NCH-1:0] result_q, result_d;
    logic [NCH-1:0] err_q, err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [NCH-1:0] sp, sn, resolved, precharged;
    logic           cnt_tmo;

    assign sp         = syn_p_q[SYNC-1];
    assign sn         = syn_n_q[SYNC-1];
    assign resolved   = sp ^ sn;
    assign precharged = ~(sp | sn);
    assign cnt_tmo    = cnt_q == CW'(TMO - 1);
    assign comp_clk   = comp_clk_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign err        = err_q;

    // shift the raw comparator outputs through the synchroniser chains
    always_comb begin
        syn_p_d[0] = comp_p;
        syn_n_d[0] = comp_n;
        for (int k = 1; k < SYNC; k++) begin
            syn_p_d[k] = syn_p_q[k-1];
            syn_n_d[k] = syn_n_q[k-1];
        end
    end

    // sequencer: phase transitions, vote tallying, fault accumulation and result formation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        vidx_d    = vidx_q;
        v_d       = v_q;
        ones_d    = ones_q;
        err_acc_d = err_acc_q;
        result_d  = result_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = EVAL;
                vidx_d    = '0;
                v_d       = mode ? VW'(NVOTE) : VW'(1);
                err_acc_d = '0;
                for (int i = 0; i < NCH; i++) ones_d[i] = '0;
            end
            EVAL: if (&resolved || cnt_tmo) begin
                state_d   = PRE;
                err_acc_d = err_acc_q | ~resolved;
                for (int i = 0; i < NCH; i++) ones_d[i] = ones_q[i] + VW'(resolved[i] & sp[i]);
            end
            PRE: if (&precharged || cnt_tmo) begin
                err_acc_d = err_acc_q | ~precharged;
                if (vidx_q == v_q - VW'(1)) begin
                    state_d = DONE;
                    err_d   = err_acc_d;
                    for (int i = 0; i < NCH; i++) result_d[i] = ones_q[i] > (v_q >> 1);
                end else begin
                    state_d = EVAL;
                    vidx_d  = vidx_q + VW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        comp_clk_d = {NCH{state_d == EVAL}};
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
    end

    // state and output registers; reset drops comparator clocks immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            vidx_q     <= '0;
            v_q        <= '0;
            err_acc_q  <= '0;
            comp_clk_q <= '0;
            result_q   <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) ones_q[i] <= '0;
            for (int k = 0; k < SYNC; k++) begin
                syn_p_q[k] <= '0;
                syn_n_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vidx_q     <= vidx_d;
            v_q        <= v_d;
            err_acc_q  <= err_acc_d;
            comp_clk_q <= comp_clk_d;
            result_q   <= result_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ones_q     <= ones_d;
            syn_p_q    <= syn_p_d;
            syn_n_q    <= syn_n_d;
        end
    end
endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: randomized and directed checks of comp_seq against a comparator model and timing formulas
module tb_comp_seq;
    localparam int NCH = 4, NVOTE = 3, SYNC = 2, TMO = 16;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic [NCH-1:0] comp_clk, result, err;
    logic [NCH-1:0] comp_p = '0, comp_n = '0;
    logic busy, done;
    int total = 0, bad = 0;

    // per-channel comparator behaviour: 0 ideal, 1 stuck 00, 2 stuck p=1 n=0, 3 stuck 11
    logic [NVOTE-1:0] dec [NCH];
    int flt [NCH];
    int eidx = -1;
    logic cc_prev = 1'b0;

    comp_seq #(.NCH(NCH), .NVOTE(NVOTE), .SYNC(SYNC), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .comp_clk(comp_clk),
        .comp_p(comp_p), .comp_n(comp_n), .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    // analog comparator model: settles shortly after each clock edge
    always @(posedge clk or negedge rst_n) begin
        int k;
        #1;
        if (comp_clk[0] && !cc_prev) eidx++;
        cc_prev = comp_clk[0];
        k = (eidx < 0) ? 0 : eidx % NVOTE;
        for (int c = 0; c < NCH; c++) begin
            case (flt[c])
                1:       {comp_p[c], comp_n[c]} = 2'b00;
                2:       {comp_p[c], comp_n[c]} = 2'b10;
                3:       {comp_p[c], comp_n[c]} = 2'b11;
                default: {comp_p[c], comp_n[c]} = comp_clk[c] ? {dec[c][k], ~dec[c][k]} : 2'b00;
            endcase
        end
    end

    // expected outcome from phase-length rules and vote counting
    function automatic void model(input int v, output int lat, output logic [NCH-1:0] r, output logic [NCH-1:0] e);
        bit unres = 0, notpre = 0;
        for (int c = 0; c < NCH; c++) begin
            int ones = 0;
            unres  |= (flt[c] == 1 || flt[c] == 3);
            notpre |= (flt[c] == 2 || flt[c] == 3);
            e[c] = flt[c] != 0;
            for (int k = 0; k < v; k++) ones += (flt[c] == 2) ? 1 : (flt[c] == 0) ? int'(dec[c][k]) : 0;
            r[c] = ones > v / 2;
        end
        lat = v * ((unres ? TMO : SYNC + 1) + (notpre ? TMO : SYNC + 1));
    endfunction

    task automatic run_dec(input logic m, output int lat, output logic [NCH-1:0] r, output logic [NCH-1:0] e,
                           output int pulses, output int odd, output logic b_at, output logic after_ok);
        logic prev = 1'b0;
        int k = 0;
        lat = -1; r = '0; e = '0; pulses = 0; odd = 0; b_at = 1'b0;
        eidx = -1;
        @(negedge clk); mode = m; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (k < 400) begin
            if (comp_clk != '0 && comp_clk != '1) odd++;
            if (comp_clk[0] && !prev) pulses++;
            prev = comp_clk[0];
            if (done) begin
                lat = k; r = result; e = err; b_at = busy;
                break;
            end
            @(negedge clk); k++;
        end
        @(negedge clk);
        after_ok = !done && !busy;
    endtask

    task automatic clear_model(input logic [NVOTE-1:0] d0, d1, d2, d3);
        dec[0] = d0; dec[1] = d1; dec[2] = d2; dec[3] = d3;
        for (int c = 0; c < NCH; c++) flt[c] = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (comp_clk !== '0) begin bad++; $display("FAIL reset_comp_clk: got %b want 0", comp_clk); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %b want 0", result); end
        total++; if (err !== '0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_decision(input string nm, input logic m);
        int lat, xl, p, odd;
        logic [NCH-1:0] r, e, xr, xe;
        logic ba, ao;
        model(m ? NVOTE : 1, xl, xr, xe);
        run_dec(m, lat, r, e, p, odd, ba, ao);
        total++; if (lat !== xl) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, xl); end
        total++; if (r !== xr) begin bad++; $display("FAIL %s_result: got %b want %b", nm, r, xr); end
        total++; if (e !== xe) begin bad++; $display("FAIL %s_err: got %b want %b", nm, e, xe); end
        total++; if (p !== (m ? NVOTE : 1)) begin bad++; $display("FAIL %s_pulses: got %0d want %0d", nm, p, m ? NVOTE : 1); end
        total++; if (odd !== 0) begin bad++; $display("FAIL %s_clk_uniform: got %0d unequal samples want 0", nm, odd); end
        total++; if (ba !== 1'b1) begin bad++; $display("FAIL %s_busy_at_done: got %b want 1", nm, ba); end
        total++; if (ao !== 1'b1) begin bad++; $display("FAIL %s_idle_after: got %b want 1", nm, ao); end
    endtask

    task automatic test_single();
        clear_model(3'b111, 3'b111, 3'b111, 3'b111);
        test_decision("single", 1'b0);
    endtask

    task automatic test_vote();
        clear_model(3'b000, 3'b000, 3'b101, 3'b000);
        test_decision("vote", 1'b1);
    endtask

    task automatic test_eval_timeout();
        clear_model(3'b011, 3'b111, 3'b110, 3'b001);
        flt[1] = 1;
        test_decision("eval_tmo", 1'b1);
    endtask

    task automatic test_pre_timeout();
        clear_model(3'b001, 3'b000, 3'b001, 3'b000);
        flt[3] = 2;
        test_decision("pre_tmo", 1'b0);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        clear_model(3'b101, 3'b010, 3'b111, 3'b000);
        eidx = -1;
        @(negedge clk); mode = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++; if (comp_clk !== '0) begin bad++; $display("FAIL rst_mid_comp_clk: got %b want 0", comp_clk); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d done pulses want 0", seen); end
        test_decision("after_rst", 1'b1);
    endtask

    task automatic test_back_to_back();
        int t[$];
        clear_model(3'b111, 3'b111, 3'b111, 3'b111);
        eidx = -1;
        @(negedge clk); mode = 1'b0; start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                t.push_back(k);
                total++; if (result !== 4'b1111) begin bad++; $display("FAIL b2b_result: got %b want 1111", result); end
            end
        end
        start = 1'b0;
        total++; if (t.size() < 4) begin bad++; $display("FAIL b2b_count: got %0d want >=4", t.size()); end
        for (int i = 1; i < t.size(); i++) begin
            total++; if (t[i] - t[i-1] !== 8) begin bad++; $display("FAIL b2b_spacing: got %0d want 8", t[i] - t[i-1]); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            for (int c = 0; c < NCH; c++) begin
                dec[c] = NVOTE'($urandom);
                flt[c] = (c == 0 || $urandom_range(3) != 0) ? 0 : int'($urandom_range(1, 3));
            end
            test_decision("random", 1'($urandom_range(1)));
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            flt[c] = 0;
            dec[c] = '0;
        end
        test_reset();
        test_single();
        test_vote();
        test_eval_timeout();
        test_pre_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/comp_seq.md
# comp_seq

Parametrised digital sequencer for a bank of clocked differential comparator macros. It drives per-channel comparator clocks, synchronises and validates the differential outputs, and enforces evaluation and precharge timeouts. It also performs optional repeated-evaluation majority voting. The block sits between the converter control logic and the analog comparator array, replacing hand-wired comparator clocking with one handshaked conversion request.

## Interface
Parameters:
- NCH, 4: number of comparator channels, >=1
- NVOTE, 3: evaluations per decision in vote mode; odd, >=1, else elaboration error
- SYNC, 2: synchroniser stages on comparator outputs, >=2
- TMO, 16: max cycles per evaluation or precharge phase, >=SYNC+2

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request decision; sampled in IDLE only
- mode  in  1  0 = single evaluation, 1 = NVOTE evaluations with majority; latched at accepted start
- comp_clk  out  NCH  comparator clocks, registered, all bits identical
- comp_p  in  NCH  comparator positive outputs, asynchronous to clk
- comp_n  in  NCH  comparator negative outputs, asynchronous to clk
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse, result/err valid
- result  out  NCH  decision per channel (1 = vin_p > vin_n), held until next done
- err  out  NCH  per-channel fault flag, held until next done

## Operation
- comp_p/comp_n each pass through a SYNC-stage flop synchroniser; FSM uses only synced values sp/sn.
- Channel resolved: sp != sn. Channel precharged: sp == 0 and sn == 0.
- States: IDLE, EVAL, PRE, DONE.
- IDLE: comp_clk=0, busy=0. start=1 -> EVAL; clears vote index, ones counters, err accumulators; latches V = mode ? NVOTE : 1.
- EVAL: comp_clk all 1. Phase counter increments per cycle. Exit to PRE when all channels resolved or counter == TMO-1. On exit, per channel: ones += sp if resolved; err |= !resolved (covers sp==sn==1 and no-decision).
- PRE: comp_clk all 0. Exit when all channels precharged or counter == TMO-1; on timeout, err |= !precharged per channel. Then vote index == V-1 -> DONE, else index++ -> EVAL.
- DONE: done=1 for one cycle; result[i] = (ones[i] > V/2); err latched from accumulator; busy stays 1; -> IDLE.
- Phase counter clears on every state entry; width $clog2(TMO). Ones counters and vote index width $clog2(NVOTE+1).
- An erroring channel's unresolved evaluations count as 0 votes; result still produced.
- start while busy is ignored; no queuing.

## Timing
- Reset values: comp_clk=0, busy=0, done=0, result=0, err=0, state IDLE, synchronisers 0. Reset mid-operation drops comp_clk asynchronously; no done is issued.
- start accepted at edge 0 -> comp_clk high and busy high after edge 0.
- Ideal comparator (outputs settle before next edge): EVAL and PRE each last SYNC+1 cycles; DONE entered at edge 2*(SYNC+1)*V; done high for the following cycle; busy falls one cycle after done.
- Defaults: single mode done after edge 6; vote mode after edge 18.
- Timeout: a phase lasts exactly TMO cycles when the condition never holds.
- start asserted in the DONE cycle is ignored; start in the first IDLE cycle is accepted.

## Test plan
- Single mode, ideal model, vin_p > vin_n on all 4 channels: start at edge 0 -> comp_clk high for 3 cycles, low for 3; done after edge 6, result=4'b1111, err=0.
- Vote mode, channel 2 model answers 1,0,1 and others 0,0,0: done after edge 18, result=4'b0100, err=0, comp_clk shows 3 high pulses.
- Channel 1 stuck sp=sn=0 in EVAL: EVAL lasts 16 cycles each evaluation, err=4'b0010, result[1]=0, others correct.
- Channel 3 stuck sp=1 during PRE: PRE lasts 16 cycles, err=4'b1000.
- rst_n low mid-EVAL in vote mode: comp_clk=0 immediately, busy=0, no done; subsequent start completes normally with done after edge 18.
- start held high continuously: back-to-back decisions, start ignored while busy; done pulses spaced 8 cycles apart in single mode.
